// File: rtl/bus_uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Optional feature macro: BUS_UART_TX_PARITY_EN (adds an even-parity bit per frame).
package bus_uart_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 16;

    // Register index, taken from address_in[3:2]
    localparam logic [1:0] REG_DATA     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_DIVISOR  = 2'd2;
    localparam logic [1:0] REG_RESERVED = 2'd3;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_PAR     = 4;
    localparam int unsigned STAT_LEVEL   = 8;
    localparam int unsigned STAT_LEVEL_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Even parity: XOR of all data bits
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/bus_uart_tx_if.sv
// Memory-bus responder signals for the UART transmitter.
interface bus_uart_tx_if;
    import bus_uart_pkg::*;

    logic             sel_in;
    logic [BUS_W-1:0] address_in;
    logic             read_in;
    logic             write_in;
    logic [3:0]       write_mask_in;
    logic [BUS_W-1:0] write_value_in;
    logic [BUS_W-1:0] read_value_out;

    modport master (
        output sel_in, address_in, read_in, write_in, write_mask_in, write_value_in,
        input  read_value_out
    );

    modport slave (
        input  sel_in, address_in, read_in, write_in, write_mask_in, write_value_in,
        output read_value_out
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous TX FIFO; a push on a full FIFO is accepted only when a pop frees a slot.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (level_q == LVL_W'(DEPTH));
    assign empty_c = (level_q == '0);
    assign dout_c  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Pointer, level and storage update
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop_i && !empty_c;
        do_push  = push_i && (!full_c || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter, frame FSM.
// Define BUS_UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module bus_uart_tx
    import bus_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd103
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_uart_tx_if.slave  bus,
    output logic          tx_out
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t         state_q, state_d;
    logic [DIV_W-1:0]  baud_q, baud_d;
    logic [DIV_W-1:0]  divisor_q, divisor_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;

    logic [1:0]        reg_idx;
    logic              wr_hit;
    logic              rd_hit;
    logic              push_c;
    logic              pop_c;
    logic              bit_done;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic [BUS_W-1:0]  read_value_c;
    logic              unused_ok;

    assign reg_idx  = bus.address_in[3:2];
    assign wr_hit   = bus.sel_in && bus.write_in;
    assign rd_hit   = bus.sel_in && bus.read_in;
    assign push_c   = wr_hit && (reg_idx == REG_DATA) && bus.write_mask_in[0];
    assign bit_done = (baud_q == '0);
    assign tx_out   = tx_q;
    assign bus.read_value_out = read_value_c;
    assign unused_ok = ^{bus.address_in[BUS_W-1:4], bus.address_in[1:0],
                         bus.write_mask_in[3:2], bus.write_value_in[BUS_W-1:16]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push_c),
        .din_i   (bus.write_value_in[DATA_W-1:0]),
        .pop_i   (pop_c),
        .dout_c  (fifo_dout),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .level_o (fifo_level)
    );

    // Control register writes: divisor bytes and sticky overflow
    always_comb begin
        divisor_d  = divisor_q;
        overflow_d = overflow_q;
        if (push_c && fifo_full && !pop_c) begin
            overflow_d = 1'b1;
        end
        if (wr_hit && (reg_idx == REG_STATUS) && bus.write_mask_in[0] && bus.write_value_in[STAT_OVF]) begin
            overflow_d = 1'b0;
        end
        if (wr_hit && (reg_idx == REG_DIVISOR)) begin
            if (bus.write_mask_in[0]) divisor_d[7:0]  = bus.write_value_in[7:0];
            if (bus.write_mask_in[1]) divisor_d[15:8] = bus.write_value_in[15:8];
        end
    end

    // Frame FSM next state, baud counter, shifter and serial output
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        tx_d      = tx_q;
        pop_c     = 1'b0;
        if ((state_q != IDLE) && !bit_done) begin
            baud_d = baud_q - DIV_W'(1);
        end
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    data_d  = fifo_dout;
                    state_d = START;
                    tx_d    = 1'b0;
                    baud_d  = divisor_q;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = data_q[0];
                    baud_d    = divisor_q;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d = divisor_q;
                    if (bit_idx_q == 3'd7) begin
`ifdef BUS_UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = even_parity(data_q);
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = data_q[bit_idx_q + 3'd1];
                    end
                end
            end
            PARITY: begin
`ifdef BUS_UART_TX_PARITY_EN
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    baud_d  = divisor_q;
                end
`else
                state_d = IDLE;
                tx_d    = 1'b1;
`endif
            end
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        data_d  = fifo_dout;
                        state_d = START;
                        tx_d    = 1'b0;
                        baud_d  = divisor_q;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Combinational read data, zero unless selected for read
    always_comb begin
        read_value_c = '0;
        if (rd_hit) begin
            unique case (reg_idx)
                REG_STATUS: begin
                    read_value_c[STAT_BUSY]  = (state_q != IDLE);
                    read_value_c[STAT_FULL]  = fifo_full;
                    read_value_c[STAT_EMPTY] = fifo_empty;
                    read_value_c[STAT_OVF]   = overflow_q;
`ifdef BUS_UART_TX_PARITY_EN
                    read_value_c[STAT_PAR]   = 1'b1;
`endif
                    read_value_c[STAT_LEVEL +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
                end
                REG_DIVISOR:  read_value_c[DIV_W-1:0] = divisor_q;
                REG_DATA,
                REG_RESERVED: read_value_c = '0;
                default:      read_value_c = '0;
            endcase
        end
    end

    // State registers; line returns to idle high as soon as reset asserts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            divisor_q  <= DEFAULT_DIVISOR;
            bit_idx_q  <= '0;
            data_q     <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            divisor_q  <= divisor_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
